// File: rtl/entrada_sensores_filtro_if.sv
// Signal bundle between the raw board inputs and the conditioned sensor outputs.
interface entrada_sensores_filtro_if;
  logic [6:0] raw_in;
  logic [6:0] clean_out;
  logic [6:0] change_stb;
  logic       tick;
  logic       sensor_fault;

  modport master (output raw_in, input clean_out, change_stb, tick, sensor_fault);
  modport slave  (input raw_in, output clean_out, change_stb, tick, sensor_fault);
endinterface

// File: rtl/entrada_sensores_filtro.sv
// Sensor input conditioning: 2-flop sync, slow sample tick, per-channel debounce.
// Define NIVEL_PLAUSIVEL_EN to add the H/M/L level-probe plausibility checker.
module entrada_sensores_filtro #(
  parameter int unsigned SAMPLE_DIV     = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned FAULT_TICKS    = 100
) (
  input  logic clock,
  input  logic reset_n,
  entrada_sensores_filtro_if.slave sens
);
  localparam int unsigned NCH = 7;
  localparam int unsigned PW  = $clog2(SAMPLE_DIV);
  localparam int unsigned CW  = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS - 1);

  if (SAMPLE_DIV < 2 || DEBOUNCE_TICKS < 1 || FAULT_TICKS < 1) begin : g_param_check
    $error("entrada_sensores_filtro: parameter below its minimum");
  end

  typedef enum logic {DB_STABLE, DB_CANDIDATE} db_state_e;

  logic [PW-1:0]  pre_q;
  logic           tick;
  logic [NCH-1:0] sync1_q, sync_q;
  logic [NCH-1:0] deb_q, deb_d, accept;
  logic [NCH-1:0] out_q, out_d, stb_q, stb_d;
  db_state_e      db_q [NCH];
  db_state_e      db_d [NCH];
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];

  assign tick = (pre_q == PW'(SAMPLE_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      sync1_q <= '0;
      sync_q  <= '0;
      deb_q   <= '0;
      out_q   <= '0;
      stb_q   <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        db_q[i]  <= DB_STABLE;
        cnt_q[i] <= '0;
      end
    end else begin
      pre_q   <= tick ? '0 : pre_q + 1'b1;
      sync1_q <= sens.raw_in;
      sync_q  <= sync1_q;
      deb_q   <= deb_d;
      out_q   <= out_d;
      stb_q   <= stb_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        db_q[i]  <= db_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        unique case (db_q[i])
          DB_STABLE: begin
            if (sync_q[i] != deb_q[i] && DEBOUNCE_TICKS > 1) begin
              db_d[i]  = DB_CANDIDATE;
              cnt_d[i] = CW'(1);
            end
          end
          DB_CANDIDATE: begin
            if (sync_q[i] == deb_q[i] || cnt_q[i] == DB_LAST) begin
              db_d[i]  = DB_STABLE;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Single-tick debounce accepts straight from STABLE; otherwise the last candidate tick accepts.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      accept[i] = tick && (sync_q[i] != deb_q[i]) &&
                  ((db_q[i] == DB_STABLE && DEBOUNCE_TICKS == 1) ||
                   (db_q[i] == DB_CANDIDATE && cnt_q[i] == DB_LAST));
    end
    deb_d = (deb_q & ~accept) | (sync_q & accept);
  end

`ifdef NIVEL_PLAUSIVEL_EN
  localparam int unsigned FW = $clog2(FAULT_TICKS + 1);

  typedef enum logic [1:0] {LV_VALID, LV_SUSPECT, LV_FAULT} lv_state_e;

  lv_state_e     lv_q, lv_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [1:0]    pcnt_q, pcnt_d;
  logic [2:0]    lvl_d;
  logic          implaus;

  // Judged on the level being latched this tick so an implausible value never reaches clean_out.
  assign implaus = (deb_d[0] & ~deb_d[1]) | (deb_d[1] & ~deb_d[2]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lv_q   <= LV_VALID;
      fcnt_q <= '0;
      pcnt_q <= '0;
    end else begin
      lv_q   <= lv_d;
      fcnt_q <= fcnt_d;
      pcnt_q <= pcnt_d;
    end
  end

  always_comb begin
    lv_d   = lv_q;
    fcnt_d = fcnt_q;
    pcnt_d = pcnt_q;
    if (tick) begin
      case (lv_q)
        LV_VALID: begin
          if (implaus) begin
            lv_d   = (FAULT_TICKS == 1) ? LV_FAULT : LV_SUSPECT;
            fcnt_d = FW'(1);
            pcnt_d = '0;
          end
        end
        LV_SUSPECT: begin
          if (!implaus) begin
            lv_d   = LV_VALID;
            fcnt_d = '0;
          end else if (fcnt_q == FW'(FAULT_TICKS - 1)) begin
            lv_d   = LV_FAULT;
            fcnt_d = '0;
            pcnt_d = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        LV_FAULT: begin
          if (implaus) begin
            pcnt_d = '0;
          end else if (pcnt_q == 2'd3) begin
            lv_d   = LV_VALID;
            pcnt_d = '0;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        default: lv_d = LV_VALID;
      endcase
    end
  end

  always_comb begin
    lvl_d = out_q[2:0];
    if (tick && lv_d == LV_VALID) lvl_d = deb_d[2:0];
    out_d = {deb_d[NCH-1:3], lvl_d};
    stb_d = {accept[NCH-1:3], lvl_d ^ out_q[2:0]};
  end

  assign sens.sensor_fault = (lv_q == LV_FAULT);
`else
  assign out_d = deb_d;
  assign stb_d = accept;
  assign sens.sensor_fault = 1'b0;
`endif

  assign sens.clean_out  = out_q;
  assign sens.change_stb = stb_q;
  assign sens.tick       = tick;
endmodule
